// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: state codes, source IDs
// and the fixed-priority winner selection.
package interrupt_controller_pkg;

    // Controller states; the encoding is visible on the IcState debug output.
    typedef enum logic [1:0] {
        IC_IDLE = 2'b00,
        IC_REQ  = 2'b01,
        IC_GAP  = 2'b10
    } ic_state_e;

    // Source IDs reported on IID_Sync.
    localparam logic EV_INT_0 = 1'b0;
    localparam logic EV_INT_1 = 1'b1;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Source 0 always beats source 1.
    function automatic logic prio_pick(input logic [1:0] eligible);
        return eligible[0] ? EV_INT_0 : EV_INT_1;
    endfunction

endpackage

// File: rtl/interrupt_controller_sync.sv
// Multi-flop synchroniser for one asynchronous interrupt line, followed by a
// rising-edge detector on the synchronised value.
module int_sync
    import interrupt_controller_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clock,
    input  logic SysReset,
    input  logic AsyncIn,
    output logic SyncOut,
    output logic RiseEdge
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Shift the raw line through the synchroniser chain; keep one cycle of history.
    always_ff @(posedge Clock or negedge SysReset) begin
        if (!SysReset) begin
            sync_q <= '0;
            hist_q <= FALSE;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], AsyncIn};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign SyncOut  = sync_q[SYNC_STAGES-1];
    assign RiseEdge = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/interrupt_controller.sv
// Two-source interrupt controller: synchronises the external lines, latches
// pending events, masks them with IntEn and presents one request (IRQ_Int /
// IID_Sync) that is held until the branch/exception controller acks it.
//
// Handshake: IRQ_Int is the valid, IntAck the one-cycle accept. While
// IRQ_Int is high, IID_Sync does not change. An IntAck seen in REQ completes
// the transfer; IntAck in any other state is ignored.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [1:0] EDGE_TRIG   = 2'b11
) (
    input  logic       Clock,
    input  logic       SysReset,
    input  logic [1:0] IntReq,
    input  logic [1:0] IntEn,
    input  logic       IntAck,
    output logic       IRQ_Int,
    output logic       IID_Sync,
    output logic [1:0] IntPending,
    output logic       IntBusy,
    output ic_state_e  IcState
);

    logic [1:0] sync_s;
    logic [1:0] rise_s;
    logic [1:0] pend_q, pend_d;
    logic [1:0] clr_s;
    logic [1:0] elig_s;
    ic_state_e  state_q, state_d;
    logic       iid_q, iid_d;

    for (genvar i = 0; i < 2; i++) begin : g_sync
        int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .Clock    (Clock),
            .SysReset (SysReset),
            .AsyncIn  (IntReq[i]),
            .SyncOut  (sync_s[i]),
            .RiseEdge (rise_s[i])
        );
    end

    // Pending next-state: edge sources latch (new edge beats ack clear), level sources follow the line.
    always_comb begin
        clr_s = '0;
        if (state_q == IC_REQ && IntAck) begin
            clr_s[iid_q] = TRUE;
        end
        for (int i = 0; i < 2; i++) begin
            pend_d[i] = EDGE_TRIG[i] ? (rise_s[i] | (pend_q[i] & ~clr_s[i])) : sync_s[i];
        end
    end

    assign elig_s = pend_q & IntEn;

    // Request FSM next-state: arbitrate in IDLE, hold in REQ, one settle cycle in GAP.
    always_comb begin
        state_d = state_q;
        iid_d   = iid_q;
        unique case (state_q)
            IC_IDLE: begin
                if (|elig_s) begin
                    iid_d   = prio_pick(elig_s);
                    state_d = IC_REQ;
                end
            end
            IC_REQ: begin
                if (IntAck) begin
                    state_d = IC_GAP;
                end else if (!IntEn[iid_q]) begin
                    state_d = IC_IDLE;
                end
            end
            IC_GAP:  state_d = IC_IDLE;
            default: state_d = IC_IDLE;
        endcase
    end

    // State, latched ID and pending flags.
    always_ff @(posedge Clock or negedge SysReset) begin
        if (!SysReset) begin
            state_q <= IC_IDLE;
            iid_q   <= EV_INT_0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            iid_q   <= iid_d;
            pend_q  <= pend_d;
        end
    end

    assign IRQ_Int    = (state_q == IC_REQ);
    assign IID_Sync   = iid_q;
    assign IntPending = pend_q;
    assign IntBusy    = (state_q != IC_IDLE);
    assign IcState    = state_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: a per-cycle vector table for the
// basic edge-mode flows, then hand-written multi-cycle sequences for
// pre-emption, enable withdrawal, async reset and level mode.
module tb_interrupt_controller;
    import interrupt_controller_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Edge-mode DUT
    logic [1:0] req = '0, en = '0;
    logic       ack = 1'b0;
    logic       irq, iid, busy;
    logic [1:0] pend;
    ic_state_e  st;

    // Level-mode DUT
    logic [1:0] l_req = '0, l_en = '0;
    logic       l_ack = 1'b0;
    logic       l_irq, l_iid, l_busy;
    logic [1:0] l_pend;
    ic_state_e  l_st;

    interrupt_controller #(.SYNC_STAGES(2), .EDGE_TRIG(2'b11)) u_dut (
        .Clock(clk), .SysReset(rst_n), .IntReq(req), .IntEn(en), .IntAck(ack),
        .IRQ_Int(irq), .IID_Sync(iid), .IntPending(pend), .IntBusy(busy), .IcState(st)
    );

    interrupt_controller #(.SYNC_STAGES(2), .EDGE_TRIG(2'b00)) u_lvl (
        .Clock(clk), .SysReset(rst_n), .IntReq(l_req), .IntEn(l_en), .IntAck(l_ack),
        .IRQ_Int(l_irq), .IID_Sync(l_iid), .IntPending(l_pend), .IntBusy(l_busy), .IcState(l_st)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outputs of the edge DUT in one go: irq, iid, pending, busy.
    task automatic check_out(input string tag, input logic e_irq, input logic e_iid,
                             input logic [1:0] e_pend, input logic e_busy);
        check({tag, " irq"},  {7'd0, irq},  {7'd0, e_irq});
        check({tag, " iid"},  {7'd0, iid},  {7'd0, e_iid});
        check({tag, " pend"}, {6'd0, pend}, {6'd0, e_pend});
        check({tag, " busy"}, {7'd0, busy}, {7'd0, e_busy});
    endtask

    task automatic check_lvl(input string tag, input logic e_irq, input logic e_iid,
                             input logic [1:0] e_pend, input logic e_busy);
        check({tag, " irq"},  {7'd0, l_irq},  {7'd0, e_irq});
        check({tag, " iid"},  {7'd0, l_iid},  {7'd0, e_iid});
        check({tag, " pend"}, {6'd0, l_pend}, {6'd0, e_pend});
        check({tag, " busy"}, {7'd0, l_busy}, {7'd0, e_busy});
    endtask

    // ---------------- driver ----------------
    // Inputs are driven 1 time unit after a rising edge; outputs sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] req;
        logic [1:0] en;
        logic       ack;
        logic       irq;
        logic       iid;
        logic [1:0] pend;
        logic       busy;
    } vec_t;

    vec_t vecs[18];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Inputs applied before an edge, expected outputs just after it.
        // Src1 edge: request visible 4 edges after the raw rise, ack, GAP, IDLE.
        vecs[0]  = '{2'b10, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
        vecs[1]  = '{2'b10, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
        vecs[2]  = '{2'b10, 2'b11, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0};
        vecs[3]  = '{2'b10, 2'b11, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1};
        vecs[4]  = '{2'b10, 2'b11, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1};
        vecs[5]  = '{2'b10, 2'b11, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1};
        vecs[6]  = '{2'b10, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
        vecs[7]  = '{2'b10, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
        vecs[8]  = '{2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
        // Both sources together: src0 first, src1 REQ exactly 2 cycles after ack.
        vecs[9]  = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
        vecs[10] = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
        vecs[11] = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0};
        vecs[12] = '{2'b11, 2'b11, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1};
        vecs[13] = '{2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1};
        vecs[14] = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0};
        vecs[15] = '{2'b11, 2'b11, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1};
        vecs[16] = '{2'b11, 2'b11, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1};
        vecs[17] = '{2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};

        // ---- reset state ----
        step();
        check_out("reset", 1'b0, 1'b0, 2'b00, 1'b0);
        check("reset state", {6'd0, st}, {6'd0, IC_IDLE});
        step();
        rst_n = 1'b1;
        en    = 2'b11;
        // Ack outside REQ is ignored.
        ack = 1'b1;
        step();
        ack = 1'b0;
        check_out("idle ack", 1'b0, 1'b0, 2'b00, 1'b0);

        // ---- table ----
        foreach (vecs[i]) begin
            req = vecs[i].req;
            en  = vecs[i].en;
            ack = vecs[i].ack;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].irq, vecs[i].iid, vecs[i].pend, vecs[i].busy);
        end
        ack = 1'b0;

        // ---- src0 edge while src1 is requested: no pre-emption ----
        req = 2'b10;
        repeat (4) step();
        check_out("pre src1 req", 1'b1, 1'b1, 2'b10, 1'b1);
        req = 2'b11;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("pre hold iid c%0d", c), {7'd0, iid}, 8'd1);
        end
        check_out("pre both pend", 1'b1, 1'b1, 2'b11, 1'b1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check_out("pre gap", 1'b0, 1'b1, 2'b01, 1'b1);
        check("pre gap state", {6'd0, st}, {6'd0, IC_GAP});
        step();
        check_out("pre idle", 1'b0, 1'b1, 2'b01, 1'b0);
        step();
        check_out("pre src0 req", 1'b1, 1'b0, 2'b01, 1'b1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        req = 2'b00;
        step();
        check_out("pre done", 1'b0, 1'b0, 2'b00, 1'b0);

        // ---- withdraw by clearing IntEn[0] in REQ ----
        req = 2'b01;
        repeat (4) step();
        check_out("wd req", 1'b1, 1'b0, 2'b01, 1'b1);
        en = 2'b10;
        step();
        check_out("wd drop", 1'b0, 1'b0, 2'b01, 1'b0);
        step();
        check_out("wd stay", 1'b0, 1'b0, 2'b01, 1'b0);
        en = 2'b11;
        step();
        check_out("wd reen", 1'b1, 1'b0, 2'b01, 1'b1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check_out("wd gap", 1'b0, 1'b0, 2'b00, 1'b1);
        req = 2'b00;
        step();

        // ---- async reset while in REQ ----
        req = 2'b10;
        repeat (4) step();
        check_out("rst req", 1'b1, 1'b1, 2'b10, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst async irq",  {7'd0, irq},  8'd0);
        check("rst async pend", {6'd0, pend}, 8'd0);
        check("rst async busy", {7'd0, busy}, 8'd0);
        req = 2'b00;
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check_out($sformatf("rst after c%0d", c), 1'b0, 1'b0, 2'b00, 1'b0);
        end

        // ---- level mode ----
        l_en  = 2'b11;
        l_req = 2'b01;
        repeat (3) step();
        check_lvl("lvl pend", 1'b0, 1'b0, 2'b01, 1'b0);
        step();
        check_lvl("lvl req", 1'b1, 1'b0, 2'b01, 1'b1);
        l_ack = 1'b1;
        step();
        l_ack = 1'b0;
        check_lvl("lvl gap", 1'b0, 1'b0, 2'b01, 1'b1);
        step();
        check_lvl("lvl idle", 1'b0, 1'b0, 2'b01, 1'b0);
        step();
        check_lvl("lvl rereq", 1'b1, 1'b0, 2'b01, 1'b1);
        l_req = 2'b00;
        repeat (4) step();
        check_lvl("lvl released", 1'b1, 1'b0, 2'b00, 1'b1);
        l_ack = 1'b1;
        step();
        l_ack = 1'b0;
        check_lvl("lvl gap2", 1'b0, 1'b0, 2'b00, 1'b1);
        for (int c = 0; c < 4; c++) begin
            step();
            check_lvl($sformatf("lvl quiet c%0d", c), 1'b0, 1'b0, 2'b00, 1'b0);
        end

        // ---- report ----
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
